// File: rtl/mod_n_updown_counter_pkg.sv
// Shared constants for the mod-N up/down counter: direction encodings and legal-N limits.
package mod_n_updown_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned N_MIN = 2;

  function automatic int unsigned n_max(input int unsigned cnt_width);
    return 32'(1) << cnt_width;
  endfunction

  function automatic bit n_is_legal(input int unsigned n, input int unsigned cnt_width);
    return (n >= N_MIN) && (n <= n_max(cnt_width));
  endfunction

endpackage

// File: rtl/mod_n_limit.sv
// Effective modulus: the runtime request when it lies in 2..N, otherwise the compile-time N.
module mod_n_limit
  import mod_n_updown_counter_pkg::*;
#(
  parameter int unsigned N         = 13,
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic [CNT_WIDTH:0] mod_n,
  output logic [CNT_WIDTH:0] modulus_c
);

  localparam int unsigned       MW  = CNT_WIDTH + 1;
  localparam logic [MW-1:0]     N_M = MW'(N);

  always_comb begin
    modulus_c = N_M;
    if ((mod_n >= MW'(N_MIN)) && (mod_n <= N_M)) begin
      modulus_c = mod_n;
    end
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Up/down counter with runtime-selectable modulus, sync clear/load, wrap pulse and
// zero-latency terminal count for cascading.
module mod_n_updown_counter
  import mod_n_updown_counter_pkg::*;
#(
  parameter int unsigned N         = 13,
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 up_dn,
  input  logic                 clr,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic [CNT_WIDTH:0]   mod_n,
  output logic [CNT_WIDTH-1:0] counter_out,
  output logic                 tc,
  output logic                 wrap
);

  localparam int unsigned MW = CNT_WIDTH + 1;

  if (!n_is_legal(N, CNT_WIDTH)) begin : g_bad_n
    $error("mod_n_updown_counter: N must lie in 2..2**CNT_WIDTH");
  end

  logic [MW-1:0]        modulus_c;
  logic [MW-1:0]        count_ext;
  logic [MW-1:0]        last_ext;
  logic [CNT_WIDTH-1:0] last_val;
  logic [CNT_WIDTH-1:0] load_sat;
  logic                 at_top;
  logic                 at_bottom;

  mod_n_limit #(
    .N         (N),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_limit (
    .mod_n     (mod_n),
    .modulus_c (modulus_c)
  );

  // Compares run one bit wider so a count stranded above a shrunken modulus is caught.
  assign count_ext = {1'b0, counter_out};
  assign last_ext  = modulus_c - MW'(1);
  assign last_val  = CNT_WIDTH'(last_ext);
  assign at_top    = count_ext >= last_ext;
  assign at_bottom = (counter_out == '0) || (count_ext >= modulus_c);
  assign load_sat  = ({1'b0, load_val} > last_ext) ? last_val : load_val;

  assign tc = enable & ((up_dn == DIR_UP) ? at_top : at_bottom);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter_out <= '0;
      wrap        <= 1'b0;
    end else if (clr) begin
      counter_out <= '0;
      wrap        <= 1'b0;
    end else if (load) begin
      counter_out <= load_sat;
      wrap        <= 1'b0;
    end else if (enable) begin
      case (up_dn)
        DIR_UP: begin
          counter_out <= at_top ? '0 : counter_out + CNT_WIDTH'(1);
          wrap        <= at_top;
        end
        DIR_DOWN: begin
          counter_out <= at_bottom ? last_val : counter_out - CNT_WIDTH'(1);
          wrap        <= at_bottom;
        end
        default: begin
          counter_out <= counter_out;
          wrap        <= 1'b0;
        end
      endcase
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Self-checking bench for mod_n_updown_counter: directed scenarios plus a randomized run
// against an integer reference model of the counting rules.
module tb_mod_n_updown_counter;

  localparam int unsigned N = 13;
  localparam int unsigned W = 4;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         up_dn;
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic [W:0]   mod_n;
  logic [W-1:0] counter_out;
  logic         tc;
  logic         wrap;

  int m_cnt;
  bit m_wrap;
  int n_checks;
  int n_pass;

  mod_n_updown_counter #(.N(N), .CNT_WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .up_dn       (up_dn),
    .clr         (clr),
    .load        (load),
    .load_val    (load_val),
    .mod_n       (mod_n),
    .counter_out (counter_out),
    .tc          (tc),
    .wrap        (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int eff_mod(input int mn);
    return (mn < 2 || mn > int'(N)) ? int'(N) : mn;
  endfunction

  function automatic bit model_tc();
    int m;
    m = eff_mod(int'(mod_n));
    if (!enable) return 1'b0;
    if (up_dn) return m_cnt >= m - 1;
    return (m_cnt == 0) || (m_cnt >= m);
  endfunction

  task automatic apply(input bit en, input bit ud, input bit c, input bit l,
                       input logic [W-1:0] lv, input logic [W:0] mn);
    enable   = en;
    up_dn    = ud;
    clr      = c;
    load     = l;
    load_val = lv;
    mod_n    = mn;
    #1;
  endtask

  // Advance one edge and move the reference model with it.
  task automatic clock();
    int m;
    m = eff_mod(int'(mod_n));
    @(posedge clk);
    if (clr) begin
      m_cnt = 0; m_wrap = 1'b0;
    end else if (load) begin
      m_cnt = (int'(load_val) < m - 1) ? int'(load_val) : m - 1;
      m_wrap = 1'b0;
    end else if (enable && up_dn) begin
      m_wrap = (m_cnt >= m - 1);
      m_cnt  = m_wrap ? 0 : m_cnt + 1;
    end else if (enable) begin
      m_wrap = (m_cnt == 0) || (m_cnt >= m);
      m_cnt  = m_wrap ? m - 1 : m_cnt - 1;
    end else begin
      m_wrap = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    apply(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (counter_out !== 4'd0 || wrap !== 1'b0)
      $display("FAIL reset: counter_out=%0d wrap=%b expected 0/0", counter_out, wrap);
    else n_pass++;
    reset = 1'b1;
    m_cnt = 0; m_wrap = 1'b0;
  endtask

  task automatic test_up_count();
    for (int i = 0; i < 14; i++) begin
      apply(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
      n_checks++;
      if (tc !== (i == 12))
        $display("FAIL up_tc step %0d: tc=%b expected %b", i, tc, (i == 12));
      else n_pass++;
      clock();
      n_checks++;
      if (counter_out !== W'((i + 1) % 13) || wrap !== (((i + 1) % 13) == 0))
        $display("FAIL up_count step %0d: counter_out=%0d wrap=%b expected %0d/%b",
                 i, counter_out, wrap, (i + 1) % 13, (((i + 1) % 13) == 0));
      else n_pass++;
    end
  endtask

  task automatic test_down_count();
    apply(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    clock();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      n_checks++;
      if (tc !== (i == 0))
        $display("FAIL down_tc step %0d: tc=%b expected %b", i, tc, (i == 0));
      else n_pass++;
      clock();
      n_checks++;
      if (counter_out !== W'(12 - i) || wrap !== (i == 0))
        $display("FAIL down_count step %0d: counter_out=%0d wrap=%b expected %0d/%b",
                 i, counter_out, wrap, 12 - i, (i == 0));
      else n_pass++;
    end
  endtask

  task automatic test_load();
    apply(1'b0, 1'b1, 1'b0, 1'b1, 4'd15, '0);
    clock();
    n_checks++;
    if (counter_out !== 4'd12 || wrap !== 1'b0)
      $display("FAIL load_sat: counter_out=%0d wrap=%b expected 12/0", counter_out, wrap);
    else n_pass++;
    apply(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, '0);
    clock();
    n_checks++;
    if (counter_out !== 4'd5 || wrap !== 1'b0)
      $display("FAIL load_over_enable: counter_out=%0d wrap=%b expected 5/0", counter_out, wrap);
    else n_pass++;
  endtask

  task automatic test_mod_change();
    for (int dir = 1; dir >= 0; dir--) begin
      apply(1'b0, 1'b1, 1'b0, 1'b1, 4'd10, '0);
      clock();
      apply(1'b0, dir[0], 1'b0, 1'b0, '0, 5'd6);
      clock();
      clock();
      n_checks++;
      if (counter_out !== 4'd10 || wrap !== 1'b0)
        $display("FAIL mod_hold dir %0d: counter_out=%0d wrap=%b expected 10/0",
                 dir, counter_out, wrap);
      else n_pass++;
      apply(1'b1, dir[0], 1'b0, 1'b0, '0, 5'd6);
      n_checks++;
      if (tc !== 1'b1) $display("FAIL mod_tc dir %0d: tc=%b expected 1", dir, tc);
      else n_pass++;
      clock();
      n_checks++;
      if (counter_out !== (dir == 1 ? 4'd0 : 4'd5) || wrap !== 1'b1)
        $display("FAIL mod_step dir %0d: counter_out=%0d wrap=%b expected %0d/1",
                 dir, counter_out, wrap, (dir == 1 ? 0 : 5));
      else n_pass++;
    end
    clock();
    n_checks++;
    if (counter_out !== 4'd4 || wrap !== 1'b0)
      $display("FAIL mod_down_next: counter_out=%0d wrap=%b expected 4/0", counter_out, wrap);
    else n_pass++;
  endtask

  task automatic test_clr_load_reset();
    apply(1'b0, 1'b1, 1'b0, 1'b1, 4'd7, '0);
    clock();
    apply(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, '0);
    clock();
    n_checks++;
    if (counter_out !== 4'd0 || wrap !== 1'b0)
      $display("FAIL clr_over_load: counter_out=%0d wrap=%b expected 0/0", counter_out, wrap);
    else n_pass++;
    apply(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, '0);
    clock();
    apply(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (counter_out !== 4'd0 || wrap !== 1'b0)
      $display("FAIL async_reset: counter_out=%0d wrap=%b expected 0/0", counter_out, wrap);
    else n_pass++;
    #1 reset = 1'b1;
    m_cnt = 0; m_wrap = 1'b0;
    apply(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    clock();
    n_checks++;
    if (counter_out !== 4'd1 || wrap !== 1'b0)
      $display("FAIL after_reset: counter_out=%0d wrap=%b expected 1/0", counter_out, wrap);
    else n_pass++;
  endtask

  task automatic test_mod_n_bounds();
    int mods [3] = '{1, 20, 2};
    int span;
    foreach (mods[k]) begin
      span = (mods[k] == 2) ? 2 : 13;
      apply(1'b0, 1'b1, 1'b1, 1'b0, '0, 5'(mods[k]));
      clock();
      for (int i = 0; i < 14; i++) begin
        apply(1'b1, 1'b1, 1'b0, 1'b0, '0, 5'(mods[k]));
        clock();
        n_checks++;
        if (counter_out !== W'((i + 1) % span) || wrap !== (((i + 1) % span) == 0))
          $display("FAIL mod_bound mod_n=%0d step %0d: counter_out=%0d wrap=%b expected %0d/%b",
                   mods[k], i, counter_out, wrap, (i + 1) % span, (((i + 1) % span) == 0));
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [W:0] mn;
    mn = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) mn = 5'($urandom_range(0, 31));
      apply($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
            $urandom_range(0, 7) == 0, 4'($urandom), mn);
      n_checks++;
      if (tc !== model_tc())
        $display("FAIL rand_tc cycle %0d: tc=%b expected %b", i, tc, model_tc());
      else n_pass++;
      clock();
      n_checks++;
      if (counter_out !== W'(m_cnt) || wrap !== m_wrap)
        $display("FAIL rand_count cycle %0d: counter_out=%0d wrap=%b expected %0d/%b",
                 i, counter_out, wrap, m_cnt, m_wrap);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_cnt    = 0;
    m_wrap   = 1'b0;
    reset    = 1'b0;
    enable   = 1'b0;
    up_dn    = 1'b1;
    clr      = 1'b0;
    load     = 1'b0;
    load_val = '0;
    mod_n    = '0;
    #6;
    test_reset();
    test_up_count();
    test_down_count();
    test_load();
    test_mod_change();
    test_clr_load_reset();
    test_mod_n_bounds();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
